lsu_mem_stage: RTL
==================

# lsu_mem_stage

Load/store unit sitting directly downstream of the pipelined datapath's memory stage. It takes the M-stage address (`aluoutM`), store data (`writedataM`) and access type, and drives a split request/response data bus. It generates byte strobes, lane-replicated store data, and sign- or zero-extended load data. It stalls the pipeline through `stallM` until the bus transaction completes or times out.

## Interface
- `MAX_WAIT`, 255, bus cycles spent in REQ+WAIT before the access is aborted with `buserr`
- `clka`  in  1  pipeline clock; all state is updated on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `memreadM`  in  1  M-stage load request
- `memwriteM`  in  1  M-stage store request; takes priority if asserted together with `memreadM`
- `lsopM`  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- `aluoutM`  in  32  effective address
- `writedataM`  in  32  store data, right-aligned
- `stallM`  out  1  freezes the F/D/E/M pipeline registers
- `rdataM`  out  32  extended load data; valid only in DONE
- `done`  out  1  one-cycle completion pulse
- `adel`, `ades`  out  1  misaligned load / store pulse
- `buserr`  out  1  timeout pulse
- `data_req`  out  1  bus request, registered
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  bus address
- `data_wstrb`  out  4  byte strobes; 0000 on reads
- `data_wdata`  out  32  lane-replicated store data
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  response valid / write acknowledged
- `data_rdata`  in  32  read data

## Operation
- **Clock and reset:** one clock, `clka`; `rst` is asynchronous and active-high.
- **States:** IDLE, REQ, WAIT, DONE, ERR.
- **IDLE**
  - An access (`memreadM|memwriteM`) that is aligned latches address, op and store data, and moves to REQ.
  - `stallM` is combinationally high in that cycle.
  - `data_data_ok` is ignored in IDLE.
- **REQ**
  - `data_req` = 1 and all bus outputs are held stable until `data_addr_ok`.
  - `addr_ok` alone moves to WAIT.
  - `addr_ok` and `data_ok` in the same cycle move straight to DONE.
- **WAIT:** `data_ok` captures `data_rdata` and moves to DONE. `data_req` = 0.
- **DONE:** one cycle. `stallM` = 0, `done` = 1, `rdataM` valid. Returns to IDLE unconditionally; no new access is accepted in DONE.
- **ERR:** entered when the wait counter reaches `MAX_WAIT` in REQ/WAIT. One cycle: `buserr` = 1, `stallM` = 0, `rdataM` = 0. Returns to IDLE.
- **Wait counter:** 8 bits. Cleared on entry to REQ, increments every REQ/WAIT cycle, saturates.
- **Stall equation:** `stallM` = (IDLE & access & aligned) | REQ | WAIT.
- **Byte strobes (little-endian)**
  - SB: `1 << addr[1:0]`
  - SH: `addr[1] ? 1100 : 0011`
  - SW: `1111`
- **Store data:** SB → `{4{wd[7:0]}}`; SH → `{2{wd[15:0]}}`; SW → `wd`.
- **Load data:** the selected lane of the captured data is sign-extended for LB/LH and zero-extended for LBU/LHU; LW passes the word through.
- **Reset (including mid-transaction):** state IDLE, counter 0, every output 0 (`data_req` drops immediately). Any response arriving after reset is ignored.

## Timing
- **Minimum load/store:** 3 cycles.
  - Cycle 0: IDLE accept, stall.
  - Cycle 1: REQ with `addr_ok` + `data_ok`.
  - Cycle 2: DONE, pipeline advances.
- Each cycle `data_addr_ok` is withheld or `data_data_ok` is delayed adds one stall cycle.
- **Timeout:** ERR is reached `MAX_WAIT` cycles after REQ entry, so `buserr` is asserted at cycle `MAX_WAIT`+1.
- `adel`/`ades` are combinational in the IDLE cycle; no bus request is issued and `stallM` stays 0.
- Bus outputs change only on the `clka` edge; they never glitch during REQ.

## Configuration
- `LSU_ALIGN_CHECK_EN`
- **Defined:**
  - LW/SW with `addr[1:0]` ≠ 0 and LH/LHU/SH with `addr[0]` = 1 raise `adel` (loads) or `ades` (stores) for one cycle.
  - The access is dropped: no FSM transition.
- **Undefined:**
  - `adel` and `ades` are tied to 0.
  - `data_addr[1:0]` is forced to 00 for word accesses; `data_addr[0]` is forced to 0 for halfword accesses.
  - The access proceeds normally.

## Test plan
- LB at `0x10000003`, `data_rdata` = `0x80FF_1234`, `addr_ok` + `data_ok` in the REQ cycle → `rdataM` = `0xFFFF_FF80`, `stallM` high for exactly 2 cycles, `done` in cycle 2.
- SH at `0x10000006`, `writedataM` = `0x0000_BEEF` → `data_wstrb` = 1100, `data_wdata` = `0xBEEF_BEEF`, `data_size` = 1, `data_wr` = 1.
- LHU with `addr_ok` delayed 3 cycles and `data_ok` delayed 2 more → `stallM` high for 7 cycles; `data_req` and `data_addr` stable throughout REQ; `rdataM` is zero-extended.
- `data_data_ok` never asserted, `MAX_WAIT` = 4 → `buserr` pulse at cycle 5, `rdataM` = 0, FSM back in IDLE.
- LW at `0x…02` → with the macro: `adel` = 1, `data_req` stays 0; without it: `data_addr` = `0x…00` and the access completes.
- `rst` asserted while in WAIT → `data_req` = 0 in the same cycle; a later `data_ok` is ignored; the next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
//   Load/store unit behind the M stage. An access is latched in IDLE and
//   driven onto a split request/response bus. The unit generates byte
//   strobes, lane-replicated store data and extended load data, and holds
//   stallM high until the bus transaction completes or times out.
//
// Ports
//   clka, rst                    clock, asynchronous active-high reset
//   memreadM, memwriteM          M-stage load / store request (store wins)
//   lsopM[2:0]                   LW LH LHU LB LBU SW SH SB (0..7)
//   aluoutM[31:0]                effective address
//   writedataM[31:0]             right-aligned store data
//   stallM                       freezes F/D/E/M pipeline registers
//   rdataM[31:0]                 extended load data, valid in DONE only
//   done, buserr, adel, ades     one-cycle completion / timeout / misalign pulses
//   data_req/wr/size/addr/wstrb/wdata   bus request side
//   data_addr_ok, data_data_ok, data_rdata   bus response side
//
// Build option
//   LSU_ALIGN_CHECK_EN  defined: misaligned accesses raise adel/ades and are
//                       dropped. Undefined: low address bits are forced to the
//                       access alignment and the access proceeds.
//
// States
//   IDLE | waiting for an access
//   REQ  | request driven, waiting for data_addr_ok
//   WAIT | request accepted, waiting for data_data_ok
//   DONE | one-cycle completion, rdataM valid
//   ERR  | one-cycle timeout report

module lsu_mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic [2:0]  lsopM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        stallM,
    output logic [31:0] rdataM,
    output logic        done,
    output logic        adel,
    output logic        ades,
    output logic        buserr,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

    localparam logic [8:0] MAX_W = 9'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q, wd_q, rd_q;
    logic [2:0]  op_q;
    logic        wr_q;

    logic        access, aligned, accept, timeout, capture;
    logic [1:0]  size_in, size_q;
    logic [31:0] addr_in;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b101:         op_size = 2'd2;
            3'b001, 3'b010, 3'b110: op_size = 2'd1;
            default:                op_size = 2'd0;
        endcase
    endfunction

    // Reset gates the request so every output is 0 while rst is held.
    assign access  = (memreadM | memwriteM) & ~rst;
    assign size_in = op_size(lsopM);
    assign size_q  = op_size(op_q);

`ifdef LSU_ALIGN_CHECK_EN
    logic misalign;
    assign misalign = ((size_in == 2'd2) && (aluoutM[1:0] != 2'b00)) ||
                      ((size_in == 2'd1) && aluoutM[0]);
    assign aligned  = ~misalign;
    assign adel     = (state_q == IDLE) & access & ~memwriteM & misalign;
    assign ades     = (state_q == IDLE) & access & memwriteM & misalign;
    assign addr_in  = aluoutM;
`else
    assign aligned  = 1'b1;
    assign adel     = 1'b0;
    assign ades     = 1'b0;
    always_comb begin
        addr_in = aluoutM;
        if (size_in == 2'd2)      addr_in[1:0] = 2'b00;
        else if (size_in == 2'd1) addr_in[0]   = 1'b0;
    end
`endif

    assign accept  = (state_q == IDLE) & access & aligned;
    // The counter is cleared on REQ entry, so it holds (cycles spent - 1).
    assign timeout = ({1'b0, cnt_q} + 9'd1) >= MAX_W;
    assign capture = ((state_q == REQ) & data_addr_ok & data_data_ok) |
                     ((state_q == WAIT) & data_data_ok);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (data_addr_ok & data_data_ok) state_d = DONE;
                else if (timeout)                state_d = ERR;
                else if (data_addr_ok)           state_d = WAIT;
            end
            WAIT: begin
                if (data_data_ok) state_d = DONE;
                else if (timeout) state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            op_q    <= 3'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= 8'd0;
                addr_q <= addr_in;
                wd_q   <= writedataM;
                op_q   <= lsopM;
                wr_q   <= memwriteM;
            end else if ((state_q == REQ || state_q == WAIT) && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (capture) rd_q <= data_rdata;
        end
    end

    assign stallM   = accept | (state_q == REQ) | (state_q == WAIT);
    assign done     = (state_q == DONE);
    assign buserr   = (state_q == ERR);
    assign data_req = (state_q == REQ);

    // Bus fields come straight from registers and are zero outside REQ.
    always_comb begin
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wstrb = 4'b0000;
        data_wdata = 32'd0;
        if (data_req) begin
            data_wr   = wr_q;
            data_size = size_q;
            data_addr = addr_q;
            if (wr_q) begin
                case (size_q)
                    2'd0: begin
                        data_wstrb = 4'b0001 << addr_q[1:0];
                        data_wdata = {4{wd_q[7:0]}};
                    end
                    2'd1: begin
                        data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                        data_wdata = {2{wd_q[15:0]}};
                    end
                    default: begin
                        data_wstrb = 4'b1111;
                        data_wdata = wd_q;
                    end
                endcase
            end
        end
    end

    assign half_sel = addr_q[1] ? rd_q[31:16] : rd_q[15:0];
    assign byte_sel = rd_q[{addr_q[1:0], 3'b000} +: 8];

    always_comb begin
        rdataM = 32'd0;
        if ((state_q == DONE) && !wr_q) begin
            case (op_q)
                3'b001:  rdataM = {{16{half_sel[15]}}, half_sel};
                3'b010:  rdataM = {16'd0, half_sel};
                3'b011:  rdataM = {{24{byte_sel[7]}}, byte_sel};
                3'b100:  rdataM = {24'd0, byte_sel};
                default: rdataM = rd_q;
            endcase
        end
    end

endmodule
